// File: rtl/font_pkg.sv
// rtl/font_pkg.sv - shared font geometry and glyph-fetch FSM states
package font_pkg;

  localparam int FONT_ROWS = 7;
  localparam int FONT_COLS = 5;
  localparam int GLYPH_W   = FONT_ROWS * FONT_COLS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } font_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; requester 0 wins the first tie
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_grant
);

  logic r_last;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = r_last ? 2'b01 : 2'b10;
    end
  end

  // The grant only counts toward fairness when the caller actually commits it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_take && (o_grant != 2'b00)) begin
      r_last <= o_grant[1];
    end
  end

endmodule

// File: rtl/font_fetch_arb.sv
// rtl/font_fetch_arb.sv - arbitrates two glyph requesters onto one font ROM and
// assembles the fetched rows into a full glyph bitmap
module font_fetch_arb #(
  parameter int FONT_ROWS = font_pkg::FONT_ROWS,
  parameter int FONT_COLS = font_pkg::FONT_COLS,
  parameter int ROM_LAT   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     req,
  input  logic [7:0]                     ascii0,
  input  logic [7:0]                     ascii1,
  output logic [1:0]                     ack,
  output logic [FONT_ROWS*FONT_COLS-1:0] glyph,
  output logic                           glyph_valid,
  output logic                           glyph_owner,
  output logic                           busy,
  output logic [7:0]                     rom_ascii,
  output logic [2:0]                     rom_row,
  input  logic [FONT_COLS-1:0]           rom_data
);

  import font_pkg::*;

  localparam int         GW       = FONT_ROWS * FONT_COLS;
  localparam logic [2:0] LAST_ROW = 3'(FONT_ROWS - 1);

  font_state_e          r_state;
  logic                 r_busy;
  logic [1:0]           r_owner_oh;
  logic [7:0]           r_rom_ascii;
  logic [2:0]           r_rom_row;
  logic                 r_valid;
  logic [1:0]           r_ack;
  logic [GW-1:0]        r_glyph;
  logic [ROM_LAT-1:0]   r_cap_vld;
  logic [2:0]           r_cap_row [ROM_LAT];

  logic [1:0]           w_grant;
  logic                 w_take;
  logic                 w_cap_now;
  logic [2:0]           w_cap_row;

  // Gated by reset so busy reads low while reset is held, whatever req does.
  assign w_take    = (r_state == ST_IDLE) && (req != 2'b00) && !reset;
  assign w_cap_now = r_cap_vld[ROM_LAT-1];
  assign w_cap_row = r_cap_row[ROM_LAT-1];

  assign busy        = r_busy | w_take;
  assign ack         = r_ack;
  assign glyph       = r_glyph;
  assign glyph_valid = r_valid;
  assign glyph_owner = r_owner_oh[1];
  assign rom_ascii   = r_rom_ascii;
  assign rom_row     = r_rom_row;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (reset),
    .i_req   (req),
    .i_take  (w_take),
    .o_grant (w_grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_owner_oh  <= 2'b00;
      r_rom_ascii <= 8'h00;
      r_rom_row   <= 3'd0;
      r_valid     <= 1'b0;
      r_ack       <= 2'b00;
    end else begin
      r_valid <= 1'b0;
      r_ack   <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_owner_oh  <= w_grant;
            r_rom_ascii <= w_grant[1] ? ascii1 : ascii0;
            r_rom_row   <= 3'd0;
            r_busy      <= 1'b1;
            r_state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (r_rom_row == LAST_ROW) begin
            r_state <= ST_DRAIN;
          end else begin
            r_rom_row <= r_rom_row + 3'd1;
          end
        end
        ST_DRAIN: begin
          if (w_cap_now && (w_cap_row == LAST_ROW)) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
            r_ack   <= r_owner_oh;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Row tags travel alongside the ROM latency so each returning word lands in its own row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap_vld <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        r_cap_row[i] <= 3'd0;
      end
    end else begin
      r_cap_vld[0] <= (r_state == ST_FETCH);
      r_cap_row[0] <= r_rom_row;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_cap_vld[i] <= r_cap_vld[i-1];
        r_cap_row[i] <= r_cap_row[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_glyph <= '0;
    end else if (w_cap_now) begin
      for (int r = 0; r < FONT_ROWS; r++) begin
        if (w_cap_row == 3'(r)) begin
          r_glyph[r*FONT_COLS +: FONT_COLS] <= rom_data;
        end
      end
    end
  end

endmodule
